score_bcd_display: RTL

- Parametrised score display driver: converts a BIN_W-bit unsigned binary value into DIGITS active-low seven-segment digit patterns.
- Conversion is a sequential shift-add-3 (double-dabble), one bit per clock, so no divide/modulo hardware is used.
- Adds a start/busy/done handshake, optional leading-zero blanking, and overflow indication.
- Sits between the game score register and the board HEX displays; outputs hold the last completed value between conversions.

---
 rtl/score_bcd_display_if.sv | 17 +
 rtl/score_bcd_display.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/score_bcd_display_if.sv
// Bus between the score register side and the BCD display driver.
interface score_bcd_display_if #(
    parameter int unsigned BIN_W  = 7,
    parameter int unsigned DIGITS = 2
);
    logic [BIN_W-1:0]    value;
    logic                load;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [7*DIGITS-1:0] seg;

    modport master (output value, output load,
                    input  busy,  input  done, input overflow, input seg);
    modport slave  (input  value, input  load,
                    output busy,  output done, output overflow, output seg);
endinterface

// File: rtl/score_bcd_display.sv
// Binary score to active-low seven-segment digits via sequential double-dabble.
module score_bcd_display #(
    parameter int unsigned BIN_W    = 7,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    score_bcd_display_if.slave   bus
);
    localparam int unsigned NIB   = DIGITS + 1;
    localparam int unsigned BCD_W = 4 * NIB;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned SEG_W = 7 * DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_t;

    state_t            state, state_d;
    logic [SR_W-1:0]   sr, sr_d, sr_adj;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              sticky, sticky_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [SEG_W-1:0]  seg_q, seg_d, seg_conv;
    logic              ovf_conv;
    logic [BCD_W-1:0]  bcd;
    logic              lead;
    logic [3:0]        nib;

    // Active-high {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] seg_on(input logic [3:0] d);
        case (d)
            4'd0:    seg_on = 7'b0111111;
            4'd1:    seg_on = 7'b0000110;
            4'd2:    seg_on = 7'b1011011;
            4'd3:    seg_on = 7'b1001111;
            4'd4:    seg_on = 7'b1100110;
            4'd5:    seg_on = 7'b1101101;
            4'd6:    seg_on = 7'b1111101;
            4'd7:    seg_on = 7'b0000111;
            4'd8:    seg_on = 7'b1111111;
            4'd9:    seg_on = 7'b1100111;
            default: seg_on = 7'b0000000;
        endcase
    endfunction

    assign bcd = sr[SR_W-1:BIN_W];

    // Add 3 to every BCD nibble that is 5 or more before the next shift.
    always_comb begin
        sr_adj = sr;
        for (int n = 0; n < int'(NIB); n++) begin
            if (sr[BIN_W + 4*n +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*n +: 4] = sr[BIN_W + 4*n +: 4] + 4'd3;
            end
        end
    end

    // Display image of the finished accumulator: dashes on overflow, else digits with optional blanking.
    always_comb begin
        ovf_conv = sticky | (bcd[BCD_W-1 -: 4] != 4'd0);
        seg_conv = '1;
        lead     = 1'b1;
        nib      = 4'd0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            nib = bcd[4*k +: 4];
            if (ovf_conv) begin
                seg_conv[7*k +: 7] = 7'b0111111;
            end else if ((BLANK_LZ != 0) && (k > 0) && lead && (nib == 4'd0)) begin
                seg_conv[7*k +: 7] = 7'b1111111;
            end else begin
                seg_conv[7*k +: 7] = ~seg_on(nib);
            end
            if (nib != 4'd0) begin
                lead = 1'b0;
            end
        end
    end

    // Next-state and next-output logic of the conversion FSM.
    always_comb begin
        state_d  = state;
        sr_d     = sr;
        cnt_d    = cnt;
        sticky_d = sticky;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        seg_d    = seg_q;
        case (state)
            S_IDLE: begin
                if (bus.load) begin
                    sr_d     = {BCD_W'(0), bus.value};
                    cnt_d    = CNT_W'(BIN_W);
                    sticky_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A bit pushed out of the top nibble also means overflow.
                sr_d     = {sr_adj[SR_W-2:0], 1'b0};
                sticky_d = sticky | sr_adj[SR_W-1];
                cnt_d    = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                seg_d   = seg_conv;
                ovf_d   = ovf_conv;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and output registers; reset blanks the display and drops any conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            seg_q  <= '1;
        end else begin
            sr     <= sr_d;
            cnt    <= cnt_d;
            sticky <= sticky_d;
            busy_q <= busy_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.seg      = seg_q;
endmodule
